action_selector: RTL and testbench

//  Epsilon-greedy action picker feeding the Q-learning agent. On start, reads the N_ACTIONS
//  Q-values for one state from action_ram (read port only) and finds the arg-max. With

---
 rtl/rl_pkg.sv | 18 +
 rtl/rl_lfsr16.sv | 25 ++
 rtl/action_selector.sv | 124 ++++++++++++
 tb/tb_action_selector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared types and sizing for the Q-learning blocks: table geometry, Q-value type,
// LFSR feedback taps and the action-selector FSM encoding.
package rl_pkg;

  localparam int unsigned N_STATES  = 16;
  localparam int unsigned N_ACTIONS = 4;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned STATE_W   = $clog2(N_STATES);
  localparam int unsigned ACT_W     = $clog2(N_ACTIONS);
  localparam int unsigned ADDR_W    = 6;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} fsm_state_t;

  typedef logic signed [DATA_W-1:0] q_t;

endpackage

// File: rtl/rl_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, taps from rl_pkg). Shared with the environment model.
module rl_lfsr16
  import rl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action picker: scans one state's Q-values from action_ram, tracks the
// signed arg-max, then either returns it or a pseudo-random action drawn from the LFSR.
module action_selector
  import rl_pkg::*;
#(
  parameter logic [7:0]  EPS_THRESH = 8'd26,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic               explore_en,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [DATA_W-1:0]  ram_data,
  output logic               busy,
  output logic               done,
  output logic [ACT_W-1:0]   action_out,
  output logic [DATA_W-1:0]  q_max_out,
  output logic               explored
);

  localparam int unsigned CNT_W = ACT_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ONE_CNT   = cnt_t'(1);
  localparam cnt_t LAST_ADDR = cnt_t'(N_ACTIONS - 1);
  localparam cnt_t LAST_CNT  = cnt_t'(N_ACTIONS);

  fsm_state_t         fsm_q;
  logic [STATE_W-1:0] state_q;
  logic               explore_q;
  cnt_t               cnt_q;
  cnt_t               cnt_inc;
  logic [ACT_W-1:0]   cmp_idx_q;
  logic [ACT_W-1:0]   arg_q;
  q_t                 max_q;
  q_t                 ram_q;
  logic [15:0]        lfsr;
  logic               explore_hit;
  logic               unused_lfsr;

  rl_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign cnt_inc     = cnt_q + ONE_CNT;
  assign ram_q       = q_t'(ram_data);
  assign explore_hit = explore_q && (lfsr[7:0] < EPS_THRESH);

  // cnt_q counts SCAN cycles; from cnt_q==1 on, ram_data holds the entry addressed one
  // cycle earlier, whose index is carried in cmp_idx_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      explore_q   <= 1'b0;
      cnt_q       <= '0;
      cmp_idx_q   <= '0;
      arg_q       <= '0;
      max_q       <= '0;
      ram_en      <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      action_out  <= '0;
      q_max_out   <= '0;
      explored    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q     <= state_in;
            explore_q   <= explore_en;
            cnt_q       <= '0;
            ram_en      <= 1'b1;
            ram_rd_addr <= {state_in, {ACT_W{1'b0}}};
            busy        <= 1'b1;
            fsm_q       <= SCAN;
          end
        end
        SCAN: begin
          cnt_q     <= cnt_inc;
          cmp_idx_q <= ram_rd_addr[ACT_W-1:0];
          // Entry 0 seeds the max; strict compare keeps ties on the lowest index.
          if (cnt_q != '0 && (cnt_q == ONE_CNT || ram_q > max_q)) begin
            max_q <= ram_q;
            arg_q <= cmp_idx_q;
          end
          if (cnt_q < LAST_ADDR) begin
            ram_rd_addr <= {state_q, cnt_inc[ACT_W-1:0]};
          end
          if (cnt_q == LAST_CNT) begin
            ram_en <= 1'b0;
            fsm_q  <= DECIDE;
          end
        end
        DECIDE: begin
          q_max_out <= max_q;
          if (explore_hit) begin
            action_out <= lfsr[ACT_W+7:8];
            explored   <= 1'b1;
          end else begin
            action_out <= arg_q;
            explored   <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// Bench for action_selector: RAM model, cycle-level behavioural reference, directed
// scenarios with literal expectations and a randomised epsilon-greedy run.
module tb_action_selector;
  import rl_pkg::*;

  localparam int NA = N_ACTIONS;
  localparam logic [15:0] SEED = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [STATE_W-1:0] state_in = '0;
  logic               explore_en = 1'b0;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [DATA_W-1:0]  ram_data = '0;
  logic               busy;
  logic               done;
  logic [ACT_W-1:0]   action_out;
  logic [DATA_W-1:0]  q_max_out;
  logic               explored;

  logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  // Reference model state
  logic [15:0]       m_lfsr = SEED;
  logic [15:0]       lfsr_used = SEED;
  bit                pend = 0;
  int                pend_k = 0;
  int                pend_state = 0;
  bit                pend_explore = 0;
  bit                exp_done = 0;
  logic [ACT_W-1:0]  exp_action = '0;
  logic [DATA_W-1:0] exp_qmax = '0;
  bit                exp_explored = 0;

  logic [ADDR_W-1:0] addr_seen [0:31];
  bit                en_seen [0:31];

  always #5 clk = ~clk;

  action_selector dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state_in    (state_in),
    .explore_en  (explore_en),
    .ram_en      (ram_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_data    (ram_data),
    .busy        (busy),
    .done        (done),
    .action_out  (action_out),
    .q_max_out   (q_max_out),
    .explored    (explored)
  );

  // action_ram read port: one-cycle latency, zero output while disabled
  always @(posedge clk) ram_data <= ram_en ? mem[ram_rd_addr] : '0;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int ref_argmax(input int s);
    int best = 0;
    for (int i = 1; i < NA; i++)
      if ($signed(mem[s*NA+i]) > $signed(mem[s*NA+best])) best = i;
    return best;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one request in flight, done N+3 edges after acceptance
  initial begin
    bit was;
    int b;
    forever begin
      @(posedge clk);
      lfsr_used = m_lfsr;
      m_lfsr    = rst ? SEED : galois(m_lfsr);
      exp_done  = 0;
      if (rst) begin
        pend = 0; exp_action = '0; exp_qmax = '0; exp_explored = 0;
      end else begin
        was = pend;
        if (pend) begin
          if (pend_k == NA + 1) begin
            pend = 0;
            exp_done = 1;
            b = ref_argmax(pend_state);
            exp_qmax = mem[pend_state*NA+b];
            if (pend_explore && lfsr_used[7:0] < 8'd26) begin
              exp_action = lfsr_used[ACT_W+7:8];
              exp_explored = 1;
            end else begin
              exp_action = ACT_W'(b);
              exp_explored = 0;
            end
          end else begin
            pend_k++;
          end
        end
        if (!was && start) begin
          pend = 1; pend_k = 0; pend_state = int'(state_in); pend_explore = explore_en;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("done", done, exp_done);
        chk("busy", busy, pend);
        chk("ram_en", ram_en, (pend && pend_k <= NA));
        if (pend && pend_k < NA)
          chk("ram_rd_addr", ram_rd_addr, (pend_state * NA) + pend_k);
        chk("action_out", action_out, exp_action);
        chk("q_max_out", q_max_out, exp_qmax);
        chk("explored", explored, exp_explored);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle (or after a timeout)
  task automatic request(input int s, input bit ex, output int lat);
    start = 1'b1; state_in = STATE_W'(s); explore_en = ex;
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    addr_seen[1] = ram_rd_addr; en_seen[1] = ram_en;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      addr_seen[lat] = ram_rd_addr; en_seen[lat] = ram_en;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, dones, n_expl, mode;
    bit found;
    logic [15:0] p;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[12] = 16'd10; mem[13] = 16'd50; mem[14] = -16'sd7; mem[15] = 16'd20;
    mem[0] = -16'sd5; mem[1] = -16'sd5; mem[2] = -16'sd9; mem[3] = -16'sd100;
    mem[4] = 16'h8000; mem[5] = 16'h7FFF; mem[6] = 16'h7FFF; mem[7] = 16'h0000;

    // Pin the reference LFSR against hand-stepped values
    chk("lfsr_model_step1", galois(SEED), 16'hE270);
    p = SEED;
    for (int k = 0; k < 6; k++) p = galois(p);
    chk("lfsr_model_step6", p, 16'hB313);

    @(negedge clk);
    chk_on = 1;
    repeat (2) @(negedge clk);
    chk("reset_action", action_out, 0);
    chk("reset_qmax", q_max_out, 0);
    chk("reset_ram_en", ram_en, 0);
    chk("reset_addr", ram_rd_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Greedy, state 3
    request(3, 0, lat);
    chk("t1_latency", lat, 7);
    chk("t1_action", action_out, 1);
    chk("t1_qmax", q_max_out, 50);
    chk("t1_explored", explored, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t1_addr", addr_seen[i], 11 + i);
      chk("t1_en", en_seen[i], 1);
    end
    chk("t1_en_decide", en_seen[6], 0);
    @(negedge clk);

    // Tie and sign extremes
    request(0, 0, lat);
    chk("t2_tie_action", action_out, 0);
    chk("t2_tie_qmax", q_max_out, 16'hFFFB);
    @(negedge clk);
    request(1, 0, lat);
    chk("t2_ext_action", action_out, 1);
    chk("t2_ext_qmax", q_max_out, 16'h7FFF);
    @(negedge clk);

    // Explore: wait for lfsr[7:0]=5, lfsr[9:8]=2 in the DECIDE cycle
    found = 0;
    for (int w = 0; w < 60000 && !found; w++) begin
      p = m_lfsr;
      for (int k = 0; k < NA + 2; k++) p = galois(p);
      if (p[7:0] == 8'd5 && p[9:8] == 2'd2) found = 1;
      else @(negedge clk);
    end
    chk("t3_window_found", found, 1);
    request(3, 1, lat);
    chk("t3_action", action_out, 2);
    chk("t3_explored", explored, 1);
    chk("t3_qmax", q_max_out, 50);
    @(negedge clk);
    found = 0;
    for (int w = 0; w < 60000 && !found; w++) begin
      p = m_lfsr;
      for (int k = 0; k < NA + 2; k++) p = galois(p);
      if (p[7:0] < 8'd26 && p[9:8] != 2'd1) found = 1;
      else @(negedge clk);
    end
    chk("t3g_window_found", found, 1);
    request(3, 0, lat);
    chk("t3g_action", action_out, 1);
    chk("t3g_explored", explored, 0);
    @(negedge clk);

    // Starts while busy are dropped; start in the done cycle is accepted
    dones = 0;
    start = 1'b1; state_in = 4'd3; explore_en = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (done) dones++;
      start = (c == 2 || c == 4);
      state_in = (c == 2 || c == 4) ? 4'd0 : 4'd3;
    end
    chk("t4_one_done", dones, 1);
    chk("t4_done_cycle7", done, 1);
    chk("t4_action", action_out, 1);
    chk("t4_qmax", q_max_out, 50);
    request(0, 0, lat);
    chk("t4_b2b_latency", lat, 7);
    chk("t4_b2b_action", action_out, 0);
    chk("t4_b2b_qmax", q_max_out, 16'hFFFB);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t4_no_extra_done", dones, 0);

    // Reset mid-scan
    start = 1'b1; state_in = 4'd3; explore_en = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_ram_en", ram_en, 0);
    chk("t5_addr", ram_rd_addr, 0);
    chk("t5_action", action_out, 0);
    chk("t5_qmax", q_max_out, 0);
    chk("t5_explored", explored, 0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5_no_done", dones, 0);
    request(1, 0, lat);
    chk("t5_after_latency", lat, 7);
    chk("t5_after_action", action_out, 1);
    @(negedge clk);

    // Random tables, exploration enabled
    n_expl = 0;
    for (int r = 0; r < 1000; r++) begin
      int s;
      s = $urandom_range(0, N_STATES - 1);
      for (int i = 0; i < NA; i++) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0: mem[s*NA+i] = 16'($urandom_range(0, 6)) - 16'd3;
          1: mem[s*NA+i] = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
          default: mem[s*NA+i] = 16'($urandom);
        endcase
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      request(s, 1, lat);
      chk("t6_latency", lat, 7);
      if (explored === 1'b1) n_expl++;
      @(negedge clk);
    end
    // ~10.2% expected; band set wide enough to absorb sampling spread
    chk("t6_explore_rate", (n_expl >= 60 && n_expl <= 140), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
